// File: rtl/melee_hit_ctl_if.sv
// ---------------------------------------------------------------------------
// melee_hit_ctl_if
// Bundle between a melee weapon / enemy driver (master) and the damage
// receiver melee_hit_ctl (slave).
//   frame_tick        : one-cycle pulse per video frame
//   draw_weapon       : melee swing active (level)
//   flip_hor_melee    : 1 = weapon left of player, 0 = right
//   pos_x/y_wpn_offset: weapon hitbox top-left corner, px
//   enemy_x/enemy_y   : enemy hitbox top-left corner, px
//   enemy_respawn     : one-cycle pulse, restore enemy
//   hit               : one-cycle pulse, damage applied
//   enemy_hp          : current hit points
//   enemy_dead        : HP reached 0 (level)
//   hurt_flash        : high during invulnerability
//   knock_left        : knockback direction of last hit, 1 = push left
// ---------------------------------------------------------------------------
interface melee_hit_ctl_if;
  logic        frame_tick;
  logic        draw_weapon;
  logic        flip_hor_melee;
  logic [11:0] pos_x_wpn_offset;
  logic [11:0] pos_y_wpn_offset;
  logic [11:0] enemy_x;
  logic [11:0] enemy_y;
  logic        enemy_respawn;
  logic        hit;
  logic [7:0]  enemy_hp;
  logic        enemy_dead;
  logic        hurt_flash;
  logic        knock_left;

  modport master (
    output frame_tick, draw_weapon, flip_hor_melee,
    output pos_x_wpn_offset, pos_y_wpn_offset, enemy_x, enemy_y,
    output enemy_respawn,
    input  hit, enemy_hp, enemy_dead, hurt_flash, knock_left
  );

  modport slave (
    input  frame_tick, draw_weapon, flip_hor_melee,
    input  pos_x_wpn_offset, pos_y_wpn_offset, enemy_x, enemy_y,
    input  enemy_respawn,
    output hit, enemy_hp, enemy_dead, hurt_flash, knock_left
  );
endinterface

// File: rtl/melee_hit_ctl.sv
// ---------------------------------------------------------------------------
// melee_hit_ctl
// Receiving end of the melee weapon: detects weapon/enemy hitbox overlap,
// applies damage once per swing, runs a frame-counted invulnerability window
// and tracks enemy death / respawn.
// Ports:
//   clk   : system clock
//   rst   : synchronous, active-high reset (priority over respawn)
//   mh_if : melee_hit_ctl_if.slave -- weapon/enemy inputs, damage outputs
// All outputs are registered; a qualifying edge shows up as hit/HP one cycle
// later.
// ---------------------------------------------------------------------------
module melee_hit_ctl #(
  parameter int WPN_W     = 40,
  parameter int WPN_H     = 20,
  parameter int ENEMY_W   = 64,
  parameter int ENEMY_H   = 64,
  parameter int HP_MAX    = 10,
  parameter int DMG       = 1,
  parameter int CD_FRAMES = 30
) (
  input  logic           clk,
  input  logic           rst,
  melee_hit_ctl_if.slave mh_if
);

  localparam logic [12:0] WPN_W13   = 13'(WPN_W);
  localparam logic [12:0] WPN_H13   = 13'(WPN_H);
  localparam logic [12:0] ENEMY_W13 = 13'(ENEMY_W);
  localparam logic [12:0] ENEMY_H13 = 13'(ENEMY_H);
  localparam logic [7:0]  HP_MAX_V  = 8'(HP_MAX);
  localparam logic [7:0]  DMG_V     = 8'(DMG);
  localparam logic [7:0]  CD_V      = 8'(CD_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COOLDOWN = 2'd1,
    DEAD     = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hp_q, hp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       hit_q, hit_d;
  logic       knock_q, knock_d;
  logic       flash_q, flash_d;
  logic       dead_q, dead_d;

  // One extra bit so box edge sums near 4095 never wrap.
  logic [12:0] wx, wy, ex, ey;
  logic        overlap;
  logic [7:0]  cnt_inc;

  assign wx = {1'b0, mh_if.pos_x_wpn_offset};
  assign wy = {1'b0, mh_if.pos_y_wpn_offset};
  assign ex = {1'b0, mh_if.enemy_x};
  assign ey = {1'b0, mh_if.enemy_y};

  // Strict compares: boxes that only share an edge do not overlap.
  assign overlap = (wx < ex + ENEMY_W13) && (ex < wx + WPN_W13) &&
                   (wy < ey + ENEMY_H13) && (ey < wy + WPN_H13);

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    hit_d   = 1'b0;
    knock_d = knock_q;

    // A released weapon re-arms; the hit branch below clears it, which is
    // what limits one swing to one hit (hits only happen with draw high).
    if (!mh_if.draw_weapon) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (mh_if.draw_weapon && armed_q && overlap) begin
          hit_d   = 1'b1;
          knock_d = mh_if.flip_hor_melee;
          armed_d = 1'b0;
          if (hp_q > DMG_V) begin
            hp_d    = hp_q - DMG_V;
            state_d = COOLDOWN;
            // A frame_tick on this same edge is deliberately not counted.
            cnt_d   = 8'd0;
          end else begin
            hp_d    = 8'd0;
            state_d = DEAD;
          end
        end
      end
      COOLDOWN: begin
        if (mh_if.frame_tick) begin
          if (cnt_inc == CD_V) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DEAD: begin
        hp_d = 8'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Respawn overrides everything above, including a coincident hit.
    if (mh_if.enemy_respawn) begin
      state_d = IDLE;
      hp_d    = HP_MAX_V;
      cnt_d   = 8'd0;
      armed_d = 1'b0;
      hit_d   = 1'b0;
      knock_d = knock_q;
    end

    // Level outputs are registered copies of the upcoming state.
    flash_d = (state_d == COOLDOWN);
    dead_d  = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q    <= HP_MAX_V;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      hit_q   <= 1'b0;
      knock_q <= 1'b0;
      flash_q <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      hit_q   <= hit_d;
      knock_q <= knock_d;
      flash_q <= flash_d;
      dead_q  <= dead_d;
    end
  end

  assign mh_if.hit        = hit_q;
  assign mh_if.enemy_hp   = hp_q;
  assign mh_if.enemy_dead = dead_q;
  assign mh_if.hurt_flash = flash_q;
  assign mh_if.knock_left = knock_q;

endmodule

// File: tb/tb_melee_hit_ctl.sv
// ---------------------------------------------------------------------------
// tb_melee_hit_ctl
// Two instances driven with identical stimulus: A (DMG=1) and B (DMG=3),
// both HP_MAX=10, CD_FRAMES=30. A hit-point / remaining-frames reference
// model is stepped every cycle for both; a vector table and hand sequences
// add explicit expectations for the corner cases.
// ---------------------------------------------------------------------------
module tb_melee_hit_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v;
  bit   tick, draw, flip, resp;
  int   wx, wy, ex, ey;

  int n_cmp = 0;
  int n_bad = 0;

  melee_hit_ctl_if ifa ();
  melee_hit_ctl_if ifb ();

  assign ifa.frame_tick       = tick;
  assign ifa.draw_weapon      = draw;
  assign ifa.flip_hor_melee   = flip;
  assign ifa.enemy_respawn    = resp;
  assign ifa.pos_x_wpn_offset = wx[11:0];
  assign ifa.pos_y_wpn_offset = wy[11:0];
  assign ifa.enemy_x          = ex[11:0];
  assign ifa.enemy_y          = ey[11:0];

  assign ifb.frame_tick       = tick;
  assign ifb.draw_weapon      = draw;
  assign ifb.flip_hor_melee   = flip;
  assign ifb.enemy_respawn    = resp;
  assign ifb.pos_x_wpn_offset = wx[11:0];
  assign ifb.pos_y_wpn_offset = wy[11:0];
  assign ifb.enemy_x          = ex[11:0];
  assign ifb.enemy_y          = ey[11:0];

  melee_hit_ctl #(.HP_MAX(10), .DMG(1), .CD_FRAMES(30)) dut_a (
    .clk(clk), .rst(rst_v), .mh_if(ifa.slave));
  melee_hit_ctl #(.HP_MAX(10), .DMG(3), .CD_FRAMES(30)) dut_b (
    .clk(clk), .rst(rst_v), .mh_if(ifb.slave));

  // Reference model: HP plus frames of invulnerability left.
  typedef struct {
    int hp;
    int cd;
    bit armed;
    bit hit;
    bit knock;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int dmg);
    bit ov;
    ov = (wx < ex + 64) && (ex < wx + 40) && (wy < ey + 64) && (ey < wy + 20);
    m.hit = 1'b0;
    if (rst_v) begin
      m.hp = 10; m.cd = 0; m.armed = 1'b0; m.knock = 1'b0;
      return m;
    end
    if (resp) begin
      m.hp = 10; m.cd = 0; m.armed = 1'b0;
      return m;
    end
    if (m.hp > 0 && m.cd == 0 && draw && m.armed && ov) begin
      m.hit   = 1'b1;
      m.hp    = (m.hp > dmg) ? m.hp - dmg : 0;
      m.knock = flip;
      m.armed = 1'b0;
      m.cd    = (m.hp > 0) ? 30 : 0;
    end else if (m.hp > 0 && m.cd > 0 && tick) begin
      m.cd = m.cd - 1;
    end
    if (!draw) m.armed = 1'b1;
    return m;
  endfunction

  function automatic logic [11:0] mpack(mdl_t m);
    logic [7:0] hp8;
    hp8 = 8'(m.hp);
    return {m.hit, hp8, (m.hp == 0), (m.cd > 0), m.knock};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, 1);
    mb = mstep(mb, 3);
    #1;
    chk("model_A", {20'd0, ifa.hit, ifa.enemy_hp, ifa.enemy_dead, ifa.hurt_flash, ifa.knock_left}, {20'd0, mpack(ma)});
    chk("model_B", {20'd0, ifb.hit, ifb.enemy_hp, ifb.enemy_dead, ifb.hurt_flash, ifb.knock_left}, {20'd0, mpack(mb)});
  endtask

  typedef struct {
    bit r, d, f, t, sp;
    int wx, wy;
    bit e_hit;
    int e_hp;
    bit e_dead, e_fl, e_kn;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int hp_exp[4];

    rst_v = 1'b1; tick = 0; draw = 0; flip = 0; resp = 0;
    wx = 0; wy = 0; ex = 100; ey = 100;

    vecs[0]  = '{1,0,0,0,0,140,120, 0,10,0,0,0};
    vecs[1]  = '{0,0,0,0,0,140,120, 0,10,0,0,0};
    vecs[2]  = '{0,1,1,0,0,140,120, 1, 9,0,1,1};
    vecs[3]  = '{0,1,1,0,0,140,120, 0, 9,0,1,1};
    vecs[4]  = '{0,0,0,1,0,140,120, 0, 9,0,1,1};
    vecs[5]  = '{1,0,0,0,0, 60,100, 0,10,0,0,0};
    vecs[6]  = '{0,0,0,0,0, 60,100, 0,10,0,0,0};
    vecs[7]  = '{0,1,0,0,0, 60,100, 0,10,0,0,0};
    vecs[8]  = '{0,1,0,0,0, 61,100, 1, 9,0,1,0};
    vecs[9]  = '{0,0,0,1,0, 61,100, 0, 9,0,1,0};
    vecs[10] = '{1,0,0,0,0,140,120, 0,10,0,0,0};
    vecs[11] = '{0,0,0,0,0,140,120, 0,10,0,0,0};
    vecs[12] = '{0,1,0,0,1,140,120, 0,10,0,0,0};
    vecs[13] = '{0,0,0,0,0,100,164, 0,10,0,0,0};
    vecs[14] = '{0,1,0,0,0,100,164, 0,10,0,0,0};
    vecs[15] = '{0,1,0,0,0,100, 80, 0,10,0,0,0};
    vecs[16] = '{0,1,1,0,0,100, 81, 1, 9,0,1,1};

    // Vector table on instance A, enemy at (100,100).
    for (int i = 0; i < 17; i++) begin
      rst_v = vecs[i].r; draw = vecs[i].d; flip = vecs[i].f;
      tick = vecs[i].t; resp = vecs[i].sp;
      wx = vecs[i].wx; wy = vecs[i].wy;
      step();
      $display("vec %0d: wpn=(%0d,%0d) draw=%0d hit=%0d hp=%0d dead=%0d flash=%0d knock=%0d",
               i, wx, wy, draw, ifa.hit, ifa.enemy_hp, ifa.enemy_dead, ifa.hurt_flash, ifa.knock_left);
      chk("vec_hit",   ifa.hit,        vecs[i].e_hit);
      chk("vec_hp",    ifa.enemy_hp,   vecs[i].e_hp);
      chk("vec_dead",  ifa.enemy_dead, vecs[i].e_dead);
      chk("vec_flash", ifa.hurt_flash, vecs[i].e_fl);
      chk("vec_knock", ifa.knock_left, vecs[i].e_kn);
    end
    rst_v = 1'b0; resp = 0; tick = 0;

    // Held swing through a whole cooldown; tick on the hit edge not counted.
    rst_v = 1; step(); rst_v = 0;
    wx = 140; wy = 120; ex = 100; ey = 100;
    draw = 0; step();
    draw = 1; flip = 1; tick = 1; step(); tick = 0;
    $display("seq held: hit=%0d hp=%0d flash=%0d", ifa.hit, ifa.enemy_hp, ifa.hurt_flash);
    chk("held_hit", ifa.hit, 1);
    chk("held_hp", ifa.enemy_hp, 9);
    chk("held_knock", ifa.knock_left, 1);
    for (int i = 1; i <= 30; i++) begin
      tick = 1; step(); tick = 0;
      chk("held_flash", ifa.hurt_flash, (i < 30) ? 1 : 0);
      step(); step();
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_nohit", ifa.hit, 0);
      chk("held_hp_keep", ifa.enemy_hp, 9);
    end
    draw = 0; step();
    draw = 1; step();
    $display("seq reswing: hit=%0d hp=%0d", ifa.hit, ifa.enemy_hp);
    chk("reswing_hit", ifa.hit, 1);
    chk("reswing_hp", ifa.enemy_hp, 8);

    // Swing during cooldown at frame 10 is ignored.
    rst_v = 1; step(); rst_v = 0;
    draw = 0; step();
    draw = 1; flip = 0; step();
    draw = 0;
    for (int i = 1; i <= 30; i++) begin
      tick = 1; step(); tick = 0;
      chk("cd_flash", ifa.hurt_flash, (i < 30) ? 1 : 0);
      draw = (i == 10);
      step();
      chk("cd_nohit", ifa.hit, 0);
      draw = 0;
      step();
    end
    chk("cd_hp", ifa.enemy_hp, 9);

    // Instance B, DMG=3: 7,4,1,0 then dead and respawn.
    rst_v = 1; step(); rst_v = 0;
    hp_exp = '{7, 4, 1, 0};
    for (int k = 0; k < 4; k++) begin
      draw = 0; step();
      draw = 1; step();
      $display("seq dmg3 hit %0d: hit=%0d hp=%0d dead=%0d", k, ifb.hit, ifb.enemy_hp, ifb.enemy_dead);
      chk("dmg3_hit", ifb.hit, 1);
      chk("dmg3_hp", ifb.enemy_hp, hp_exp[k]);
      draw = 0;
      for (int j = 0; j < 31; j++) begin
        tick = 1; step(); tick = 0; step();
      end
    end
    chk("dmg3_dead", ifb.enemy_dead, 1);
    chk("dmg3_dead_flash", ifb.hurt_flash, 0);
    draw = 1; step();
    chk("dead_nohit", ifb.hit, 0);
    chk("dead_hp", ifb.enemy_hp, 0);
    draw = 0; resp = 1; step(); resp = 0;
    $display("seq respawn: hp=%0d dead=%0d", ifb.enemy_hp, ifb.enemy_dead);
    chk("respawn_hp", ifb.enemy_hp, 10);
    chk("respawn_dead", ifb.enemy_dead, 0);

    // Respawn on a qualifying edge wins; reset mid-cooldown restores all.
    rst_v = 1; step(); rst_v = 0;
    draw = 0; step();
    draw = 1; resp = 1; step(); resp = 0;
    chk("resp_vs_hit_hit", ifa.hit, 0);
    chk("resp_vs_hit_hp", ifa.enemy_hp, 10);
    draw = 0; step();
    draw = 1; flip = 1; step();
    chk("pre_rst_flash", ifa.hurt_flash, 1);
    draw = 0; step(); step();
    rst_v = 1; step(); rst_v = 0;
    $display("seq rst mid-cooldown: hit=%0d hp=%0d flash=%0d knock=%0d",
             ifa.hit, ifa.enemy_hp, ifa.hurt_flash, ifa.knock_left);
    chk("rst_cd_hp", ifa.enemy_hp, 10);
    chk("rst_cd_flash", ifa.hurt_flash, 0);
    chk("rst_cd_knock", ifa.knock_left, 0);
    chk("rst_cd_dead", ifa.enemy_dead, 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_v = ($urandom_range(0, 299) == 0);
      resp  = ($urandom_range(0, 99) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) draw = ~draw;
      flip  = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) begin
        ex = 4000 + $urandom_range(0, 95);
        ey = 4000 + $urandom_range(0, 95);
      end else if (c % 50 == 0) begin
        ex = 60 + $urandom_range(0, 240);
        ey = 60 + $urandom_range(0, 240);
      end
      wx = ex - 60 + $urandom_range(0, 140);
      wy = ey - 40 + $urandom_range(0, 120);
      if (wx > 4095) wx = 4095;
      if (wy > 4095) wy = 4095;
      step();
      if (ifa.hit || ifb.hit)
        $display("rnd %0d: hitA=%0d hpA=%0d hitB=%0d hpB=%0d", c, ifa.hit, ifa.enemy_hp, ifb.hit, ifb.enemy_hp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
